// File: rtl/lutram_cfg_loader.sv
// Packs a valid/ready word stream into NUM_LUTS-wide rows and writes one row per LUTRAM address.
// Optional macro ZUMA_CFG_CHECKSUM_EN adds the cfg_checksum output (running XOR of accepted words).
`ifndef ZUMA_LUT_SIZE
`define ZUMA_LUT_SIZE 6
`endif

module lutram_cfg_loader #(
    parameter int NUM_LUTS      = 64,
    parameter int WORD_WIDTH    = 32,
    parameter int ZUMA_LUT_SIZE = `ZUMA_LUT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [5:0]            lut_a,
    output logic [NUM_LUTS-1:0]   lut_d,
    output logic                  lut_we,
    output logic                  busy,
    output logic                  done
`ifdef ZUMA_CFG_CHECKSUM_EN
    ,
    output logic [WORD_WIDTH-1:0] cfg_checksum
`endif
);

    localparam int W     = (NUM_LUTS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int ROW_W = W * WORD_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [5:0]       LAST_ADDR = 6'((1 << ZUMA_LUT_SIZE) - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          addr_q, addr_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [5:0]          lut_a_q, lut_a_d;
    logic [NUM_LUTS-1:0] lut_d_q, lut_d_d;
`ifdef ZUMA_CFG_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] cfg_checksum_q, cfg_checksum_d;
    assign cfg_checksum = cfg_checksum_q;
`endif

    assign lut_a = lut_a_q;
    assign lut_d = lut_d_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        row_d      = row_q;
        lut_a_d    = lut_a_q;
        lut_d_d    = lut_d_q;
`ifdef ZUMA_CFG_CHECKSUM_EN
        cfg_checksum_d = cfg_checksum_q;
`endif
        cfg_ready  = 1'b0;
        lut_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    state_d    = ST_COLLECT;
                    addr_d     = '0;
                    word_cnt_d = '0;
                    row_d      = '0;
`ifdef ZUMA_CFG_CHECKSUM_EN
                    cfg_checksum_d = '0;
`endif
                end
            end
            ST_COLLECT: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) begin
                    for (int unsigned i = 0; i < W; i++) begin
                        if (word_cnt_q == CNT_W'(i)) begin
                            row_d[i*WORD_WIDTH +: WORD_WIDTH] = cfg_data;
                        end
                    end
`ifdef ZUMA_CFG_CHECKSUM_EN
                    cfg_checksum_d = cfg_checksum_q ^ cfg_data;
`endif
                    // Output registers load on the final accept so they present the row during WRITE
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_WRITE;
                        lut_a_d = addr_q;
                        lut_d_d = row_d[NUM_LUTS-1:0];
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                lut_we = 1'b1;
                busy   = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    word_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            row_q      <= '0;
            lut_a_q    <= '0;
            lut_d_q    <= '0;
`ifdef ZUMA_CFG_CHECKSUM_EN
            cfg_checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            row_q      <= row_d;
            lut_a_q    <= lut_a_d;
            lut_d_q    <= lut_d_d;
`ifdef ZUMA_CFG_CHECKSUM_EN
            cfg_checksum_q <= cfg_checksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_lutram_cfg_loader.sv
// Bench for lutram_cfg_loader: vector table, streaming/random loads against a row-packing model, 40-LUT instance.
module tb_lutram_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, lut_we, busy, done;
    logic [5:0]  lut_a;
    logic [63:0] lut_d;

    logic        start2 = 1'b0;
    logic [31:0] cfg_data2 = '0;
    logic        cfg_valid2 = 1'b0;
    logic        cfg_ready2, lut_we2, busy2, done2;
    logic [5:0]  lut_a2;
    logic [39:0] lut_d2;
`ifdef ZUMA_CFG_CHECKSUM_EN
    logic [31:0] cfg_checksum, cfg_checksum2;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] lram [64];

    always #5 clk = ~clk;

    lutram_cfg_loader #(.NUM_LUTS(64), .WORD_WIDTH(32), .ZUMA_LUT_SIZE(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .lut_a(lut_a), .lut_d(lut_d), .lut_we(lut_we), .busy(busy), .done(done)
`ifdef ZUMA_CFG_CHECKSUM_EN
        , .cfg_checksum(cfg_checksum)
`endif
    );

    lutram_cfg_loader #(.NUM_LUTS(40), .WORD_WIDTH(32), .ZUMA_LUT_SIZE(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cfg_data(cfg_data2), .cfg_valid(cfg_valid2),
        .cfg_ready(cfg_ready2), .lut_a(lut_a2), .lut_d(lut_d2), .lut_we(lut_we2), .busy(busy2), .done(done2)
`ifdef ZUMA_CFG_CHECKSUM_EN
        , .cfg_checksum(cfg_checksum2)
`endif
    );

    // Behavioural LUTRAM bank fed by the write port
    always @(posedge clk) if (lut_we) lram[lut_a] <= lut_d;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_we"},    lut_we, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_a"},     lut_a, 0);
        chk({tag, "_d"},     lut_d, 0);
`ifdef ZUMA_CFG_CHECKSUM_EN
        chk({tag, "_cks"},   cfg_checksum, 0);
`endif
    endtask

    // Full 64-row load; p_valid is the percentage of cycles cfg_valid is high
    task automatic load1(input int p_valid, input bit pattern);
        logic [31:0] words [128];
        logic [63:0] img [64];
        int wi, r, cyc;
        bit pend;
        for (int i = 0; i < 128; i++)
            words[i] = pattern ? ((i % 2 == 0) ? 32'(i / 2) : 32'hFFFF_0000 + 32'(i / 2)) : $urandom;
        for (int i = 0; i < 64; i++) img[i] = {words[2*i+1], words[2*i]};

        start = 1'b1; cfg_valid = 1'b0;
        step();
        start = 1'b0;
        chk("start_ready", cfg_ready, 1);
        chk("start_busy",  busy, 1);
        chk("start_done",  done, 0);

        wi = 0; r = 0; pend = 0; cyc = 0;
        while (r < 64 && cyc < 4000) begin
            cfg_valid = (p_valid >= 100) || ($urandom_range(0, 99) < p_valid);
            cfg_data  = cfg_valid ? words[wi] : $urandom;
            start     = ($urandom_range(0, 9) == 0);
            chk("ld_ready", cfg_ready, {63'b0, !pend});
            chk("ld_we",    lut_we, {63'b0, pend});
            chk("ld_busy",  busy, 1);
            chk("ld_done",  done, 0);
            if (pend) begin
                chk("ld_a", lut_a, r);
                chk("ld_d", lut_d, img[r]);
                r++;
                pend = 0;
            end else if (cfg_valid) begin
                wi++;
                if (wi % 2 == 0) pend = 1;
            end
            step();
            cyc++;
        end
        start = 1'b0; cfg_valid = 1'b0;
        chk("end_done",  done, 1);
        chk("end_busy",  busy, 0);
        chk("end_ready", cfg_ready, 0);
        chk("end_we",    lut_we, 0);
        if (p_valid >= 100) chk("load_cycles", cyc, 192);
        for (int i = 0; i < 64; i++) chk("lram", lram[i], img[i]);
    endtask

    task automatic load2(input bit cks);
        logic [31:0] words [128];
        logic [31:0] x;
        logic [63:0] row;
        int wi, r, cyc;
        x = '0;
        for (int i = 0; i < 128; i++) begin
            words[i] = cks ? ((i == 127) ? 32'h0000_0001 : 32'hA5A5_A5A5) : ($urandom | 32'hFF00_0000);
            x ^= words[i];
        end
        start2 = 1'b1; cfg_valid2 = 1'b0;
        step();
        start2 = 1'b0; cfg_valid2 = 1'b1;
        wi = 0; r = 0; cyc = 0;
        while (!done2 && cyc < 400) begin
            cfg_data2 = (wi < 128) ? words[wi] : '0;
            if (lut_we2) begin
                row = {words[2*r+1], words[2*r]};
                chk("d2_a", lut_a2, r);
                chk("d2_d", lut_d2, row[39:0]);
                r++;
            end else if (cfg_ready2) begin
                wi++;
            end
            step();
            cyc++;
        end
        cfg_valid2 = 1'b0;
        chk("d2_rows", r, 64);
        chk("d2_done", done2, 1);
`ifdef ZUMA_CFG_CHECKSUM_EN
        chk("d2_cks", cfg_checksum2, cks ? 32'hA5A5_A5A4 : x);
`endif
    endtask

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        e_ready;
        logic        e_we;
        logic        e_busy;
        logic        e_done;
        logic [5:0]  e_a;
        logic [63:0] e_d;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int cnt;
        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h0};
        tbl[2] = '{1'b0, 1'b0, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h0};
        tbl[3] = '{1'b0, 1'b0, 32'hDEAD_0001, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h9ABC_DEF0_1234_5678};
        tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h9ABC_DEF0_1234_5678};
        tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h9ABC_DEF0_1234_5678};
        tbl[7] = '{1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 64'h9ABC_DEF0_1234_5678};
        tbl[8] = '{1'b1, 1'b1, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 64'hCAFE_BABE_0BAD_F00D};

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_idle_zero("rst");
        step();
        step();
        chk("idle_ready", cfg_ready, 0);
        chk("idle_ready2", cfg_ready2, 0);

        foreach (tbl[i]) begin
            start = tbl[i].start; cfg_valid = tbl[i].valid; cfg_data = tbl[i].data;
            step();
            chk($sformatf("v%0d_ready", i), cfg_ready, tbl[i].e_ready);
            chk($sformatf("v%0d_we", i),    lut_we,    tbl[i].e_we);
            chk($sformatf("v%0d_busy", i),  busy,      tbl[i].e_busy);
            chk($sformatf("v%0d_done", i),  done,      tbl[i].e_done);
            chk($sformatf("v%0d_a", i),     lut_a,     tbl[i].e_a);
            chk($sformatf("v%0d_d", i),     lut_d,     tbl[i].e_d);
        end
        start = 1'b0; cfg_valid = 1'b0;

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_zero("rst_mid");

        load1(100, 1'b1);
        load1(60, 1'b0);

        start = 1'b1;
        step();
        start = 1'b0; cfg_valid = 1'b1;
        cnt = 0;
        while (!(lut_we && lut_a == 6'd20) && cnt < 500) begin
            cfg_data = $urandom;
            step();
            cnt++;
        end
        chk("reach_a20", {lut_we, lut_a}, {1'b1, 6'd20});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; cfg_valid = 1'b0;
        chk_idle_zero("rst_a20");
        load1(80, 1'b0);

        load2(1'b0);
        load2(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
